alu_scheduler: RTL and testbench
================================

# alu_scheduler

Shares one ALU between THREADS requesters (one per thread in a core) so a core can run with a single ALU instead of one per thread. It round-robin arbitrates pending requests, drives the ALU's control and operand inputs for one EXECUTE cycle, captures `alu_out`, and holds each result in a per-thread slot until the owner acknowledges it. It sits between the per-thread register files/decoders and a single `alu` instance.

## Interface
- THREADS, 4: number of requesters (2..8).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  THREADS  thread t has an ALU operation pending.
- req_arith_mux  in  2*THREADS  per-thread op: ADD 00, SUB 01, MUL 10, DIV 11 (thread t at [2t+1:2t]).
- req_output_mux  in  THREADS  1 = compare (NZP) result, 0 = arithmetic.
- req_rs, req_rt  in  8*THREADS each  per-thread operands (thread t at [8t+7:8t]).
- req_ready  out  1-hot THREADS  one-cycle pulse: the request has been accepted and its operands latched.
- resp_valid  out  THREADS  result slot t is full.
- resp_data  out  8*THREADS  result slot contents.
- resp_ack  in  THREADS  pulse clears slot t.
- div_zero  out  THREADS  slot t holds a divide-by-zero result.
- alu_core_state  out  3  3'b101 (EXECUTE) for exactly one cycle per operation, else 3'b000.
- alu_arith_mux  out  2, alu_output_mux  out  1, alu_rs / alu_rt  out  8  latched operands to the ALU.
- alu_out  in  8  ALU registered result.
- busy  out  1  FSM is not in ARB.

## Operation
- FSM states: ARB, EXEC, CAPTURE.
- ARB:
  - Eligible set = req_valid & ~resp_valid.
  - If the set is non-empty, pick the first eligible thread strictly after `last_grant` (wrapping).
  - Pulse `req_ready[g]`, latch the op and operands into the alu_* registers and store `g`, then go to EXEC.
  - If the set is empty, stay in ARB.
- EXEC: `alu_core_state` = 3'b101, so the ALU computes on this edge. Go to CAPTURE.
- CAPTURE:
  - Write `alu_out` to `resp_data[g]`, set `resp_valid[g]`, set `last_grant` = g, then go to ARB.
- `resp_ack[t]` clears `resp_valid[t]` and `div_zero[t]`.
  - An ack to an empty slot is ignored.
  - An ack arriving in the same cycle as a CAPTURE write to a different slot is honoured independently.
  - A CAPTURE write always targets an empty slot, so an ack and a write never collide on one slot.
- A thread whose slot is full is not eligible, so each thread has at most one operation in flight or buffered.
- A requester dropping `req_valid` after `req_ready` has no effect; its operands are already latched.
- Widths: all data is 8-bit and the scheduler does no arithmetic on it. The result is whatever the ALU produces (mod-256 wrap).
- Reset values: FSM = ARB, `last_grant` = THREADS-1 (so thread 0 wins first), all outputs 0, `alu_core_state` = 3'b000.
- Reset mid-operation: the in-flight operation is discarded and no `resp_valid` is raised for it.

## Timing
- Request seen in ARB in cycle 0: `req_ready` pulses in cycle 0; EXEC is cycle 1; `alu_out` is valid in cycle 2 (CAPTURE); `resp_valid` is high from cycle 3.
- Throughput: one operation per 3 cycles. ARB is entered again in cycle 3, so back-to-back grants are 3 cycles apart.
- Ack latency: `resp_valid` falls in the cycle after the `resp_ack` edge. The thread becomes eligible in that same cycle.

## Configuration
- `ALU_DIV_ZERO_EN` defined: in CAPTURE, if op = DIV, `output_mux` = 0 and latched rt = 0:
  - write 8'hFF instead of `alu_out`;
  - set `div_zero[g]`.
- `ALU_DIV_ZERO_EN` undefined: `alu_out` is forwarded unchanged and `div_zero` is tied to 0.

## Structure
- Shared package `gpu_alu_pkg`:
  - op codes ADD/SUB/MUL/DIV;
  - core-state constants IDLE 3'b000 and EXECUTE 3'b101;
  - scheduler state enum {ARB, EXEC, CAPTURE}.
- One sub-module `rr_arbiter`: parameter N; inputs `req[N]` and `last[$clog2(N)]`; outputs one-hot `gnt` and `any`. It is combinational; the pointer lives in `alu_scheduler`.

## Test plan
- Single request: thread 1 ADD rs=200, rt=100 -> `req_ready` = 0010 in cycle 0, `alu_core_state` = 101 in cycle 1, `resp_data[1]` = 8'd44 and `resp_valid[1]` = 1 in cycle 3.
- Fairness: all 4 threads valid continuously, acking every result immediately -> grant order 0,1,2,3,0,…, each grant 3 cycles apart.
- Slot full blocks: thread 0 result not acked, threads 0 and 2 valid -> thread 2 is granted next; thread 0 is re-granted only after `resp_ack[0]`.
- Compare op: `output_mux` = 1, rs=5, rt=5 -> `resp_data` = 8'b0000_0010.
- Divide by zero: DIV rs=9, rt=0 -> with `ALU_DIV_ZERO_EN`, data 8'hFF and `div_zero` = 1, then `resp_ack` clears both; without the macro, `div_zero` stays 0.
- Reset mid-op: assert reset during EXEC -> all outputs 0 immediately, no `resp_valid`, and the first grant after release goes to thread 0.

Source files
------------

// File: rtl/gpu_alu_pkg.sv
// Shared definitions for the single-ALU scheduler: opcodes, core-state codes
// presented to the ALU, and the scheduler FSM encoding.
package gpu_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;

  typedef enum logic [1:0] {
    ST_ARB     = 2'b00,
    ST_EXEC    = 2'b01,
    ST_CAPTURE = 2'b10
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after `last`,
// wrapping. The pointer is owned by the instantiating block.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/alu_scheduler.sv
// Time-shares one ALU across THREADS requesters: ARB -> EXEC -> CAPTURE, one op per 3 cycles,
// results parked per thread until acked. ALU_DIV_ZERO_EN turns DIV-by-zero into 8'hFF + div_zero flag.
module alu_scheduler
  import gpu_alu_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [THREADS-1:0]     req_valid,
  input  logic [2*THREADS-1:0]   req_arith_mux,
  input  logic [THREADS-1:0]     req_output_mux,
  input  logic [8*THREADS-1:0]   req_rs,
  input  logic [8*THREADS-1:0]   req_rt,
  output logic [THREADS-1:0]     req_ready,
  output logic [THREADS-1:0]     resp_valid,
  output logic [8*THREADS-1:0]   resp_data,
  input  logic [THREADS-1:0]     resp_ack,
  output logic [THREADS-1:0]     div_zero,
  output logic [2:0]             alu_core_state,
  output logic [1:0]             alu_arith_mux,
  output logic                   alu_output_mux,
  output logic [7:0]             alu_rs,
  output logic [7:0]             alu_rt,
  input  logic [7:0]             alu_out,
  output logic                   busy
);

  localparam int TW = $clog2(THREADS);

  sched_state_e     state_q, state_d;
  logic [TW-1:0]    last_q, last_d;
  logic [TW-1:0]    gidx_q, gidx_d;
  logic [1:0]       op_q, op_d;
  logic             om_q, om_d;
  logic [7:0]       rs_q, rs_d;
  logic [7:0]       rt_q, rt_d;
  logic [THREADS-1:0] resp_valid_q, resp_valid_d;
  logic [THREADS-1:0] div_zero_q, div_zero_d;
  logic [7:0]       slot_q [THREADS];
  logic [7:0]       slot_d [THREADS];

  logic [THREADS-1:0] eligible, gnt, cap_vec;
  logic             any;
  logic [TW-1:0]    gnt_idx;
  logic [1:0]       sel_op;
  logic             sel_om;
  logic [7:0]       sel_rs, sel_rt;
  logic             dz;
  logic [7:0]       cap_data;

  // A full slot blocks its owner, capping each thread at one op in flight or buffered.
  assign eligible = req_valid & ~resp_valid_q;

  rr_arbiter #(.N(THREADS)) u_arb (
    .req  (eligible),
    .last (last_q),
    .gnt  (gnt),
    .any  (any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:     if (any) state_d = ST_EXEC;
      ST_EXEC:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_ARB;
      default:    state_d = ST_ARB;
    endcase
  end

  always_comb begin
    req_ready      = '0;
    alu_core_state = CORE_IDLE;
    busy           = 1'b1;
    case (state_q)
      ST_ARB: begin
        busy = 1'b0;
        if (!reset) req_ready = gnt;
      end
      ST_EXEC: alu_core_state = CORE_EXECUTE;
      default: ;
    endcase
  end

  always_comb begin
    gnt_idx = '0;
    sel_op  = '0;
    sel_om  = 1'b0;
    sel_rs  = '0;
    sel_rt  = '0;
    for (int t = 0; t < THREADS; t++) begin
      if (gnt[t]) begin
        gnt_idx = TW'(t);
        sel_op  = req_arith_mux[2*t +: 2];
        sel_om  = req_output_mux[t];
        sel_rs  = req_rs[8*t +: 8];
        sel_rt  = req_rt[8*t +: 8];
      end
    end
  end

`ifdef ALU_DIV_ZERO_EN
  assign dz       = (op_q == OP_DIV) && !om_q && (rt_q == 8'd0);
  assign cap_data = dz ? 8'hFF : alu_out;
`else
  assign dz       = 1'b0;
  assign cap_data = alu_out;
`endif

  always_comb begin
    op_d   = op_q;
    om_d   = om_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    gidx_d = gidx_q;
    last_d = last_q;
    if (state_q == ST_ARB && any) begin
      op_d   = sel_op;
      om_d   = sel_om;
      rs_d   = sel_rs;
      rt_d   = sel_rt;
      gidx_d = gnt_idx;
    end
    if (state_q == ST_CAPTURE) last_d = gidx_q;

    cap_vec = '0;
    for (int t = 0; t < THREADS; t++)
      cap_vec[t] = (state_q == ST_CAPTURE) && (gidx_q == TW'(t));

    // Capture only ever lands on an empty slot, so ack and write never meet on one bit.
    resp_valid_d = (resp_valid_q & ~resp_ack) | cap_vec;
    div_zero_d   = (div_zero_q & ~resp_ack) | (dz ? cap_vec : '0);
    slot_d       = slot_q;
    for (int t = 0; t < THREADS; t++)
      if (cap_vec[t]) slot_d[t] = cap_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q       <= TW'(THREADS - 1);
      gidx_q       <= '0;
      op_q         <= '0;
      om_q         <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      resp_valid_q <= '0;
      div_zero_q   <= '0;
      for (int t = 0; t < THREADS; t++) slot_q[t] <= '0;
    end else begin
      last_q       <= last_d;
      gidx_q       <= gidx_d;
      op_q         <= op_d;
      om_q         <= om_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      resp_valid_q <= resp_valid_d;
      div_zero_q   <= div_zero_d;
      slot_q       <= slot_d;
    end
  end

  always_comb begin
    resp_data = '0;
    for (int t = 0; t < THREADS; t++) resp_data[8*t +: 8] = slot_q[t];
  end

  assign resp_valid     = resp_valid_q;
  assign div_zero       = div_zero_q;
  assign alu_arith_mux  = op_q;
  assign alu_output_mux = om_q;
  assign alu_rs         = rs_q;
  assign alu_rt         = rt_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler with a behavioural registered ALU; grant and
// response scoreboards are popped by monitors independent of the stimulus.
module tb_alu_scheduler;

  localparam int N = 4;

`ifdef ALU_DIV_ZERO_EN
  localparam logic [7:0] DZ_DATA = 8'hFF;
  localparam logic       DZ_FLAG = 1'b1;
`else
  localparam logic [7:0] DZ_DATA = 8'h00;
  localparam logic       DZ_FLAG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_arith_mux;
  logic [N-1:0]   req_output_mux;
  logic [8*N-1:0] req_rs, req_rt;
  logic [N-1:0]   req_ready, resp_valid, resp_ack, div_zero;
  logic [8*N-1:0] resp_data;
  logic [2:0]     alu_core_state;
  logic [1:0]     alu_arith_mux;
  logic           alu_output_mux;
  logic [7:0]     alu_rs, alu_rt;
  logic [7:0]     alu_out = 8'h00;
  logic           busy;

  logic [N-1:0]   man_ack = '0;
  logic [N-1:0]   auto_ack = '0;
  bit             auto_en = 1'b0;
  assign resp_ack = man_ack | auto_ack;

  alu_scheduler #(.THREADS(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_arith_mux(req_arith_mux),
    .req_output_mux(req_output_mux), .req_rs(req_rs), .req_rt(req_rt),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ack(resp_ack), .div_zero(div_zero),
    .alu_core_state(alu_core_state), .alu_arith_mux(alu_arith_mux),
    .alu_output_mux(alu_output_mux), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic om,
                                         input logic [7:0] rs, input logic [7:0] rt);
    if (om) return {5'b0, rs > rt, rs == rt, rs < rt};
    case (op)
      2'b00:   return rs + rt;
      2'b01:   return rs - rt;
      2'b10:   return rs * rt;
      default: return (rt == 8'd0) ? 8'h00 : rs / rt;
    endcase
  endfunction

  always @(posedge clk)
    if (alu_core_state == 3'b101)
      alu_out <= alu_ref(alu_arith_mux, alu_output_mux, alu_rs, alu_rt);

  always @(posedge clk) begin
    #2;
    auto_ack = auto_en ? resp_valid : '0;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  typedef struct { logic [N-1:0] oh; int gap; } gexp_t;
  typedef struct { int thr; logic [7:0] data; logic dz; } rexp_t;
  gexp_t q_gnt[$];
  rexp_t q_resp[$];

  task automatic push_g(input logic [N-1:0] oh, input int gap);
    gexp_t e;
    e.oh = oh; e.gap = gap;
    q_gnt.push_back(e);
  endtask

  task automatic push_r(input int thr, input logic [7:0] data, input logic dz);
    rexp_t e;
    e.thr = thr; e.data = data; e.dz = dz;
    q_resp.push_back(e);
  endtask

  // Grant monitor
  int last_gnt_cyc = 0;
  always @(negedge clk) begin
    if (req_ready != '0) begin
      n_checks++;
      if (q_gnt.size() == 0) begin
        $display("FAIL gnt_unexpected: actual req_ready %b, required no grant", req_ready);
      end else begin
        gexp_t e;
        n_pass++;
        e = q_gnt.pop_front();
        chk("gnt_order", req_ready, e.oh);
        if (e.gap != 0) chk("gnt_gap", cyc - last_gnt_cyc, e.gap);
      end
      last_gnt_cyc = cyc;
    end
  end

  // Response monitor: a rising resp_valid bit marks a new result
  logic [N-1:0] rv_prev = '0;
  always @(negedge clk) begin
    for (int t = 0; t < N; t++) begin
      if (resp_valid[t] && !rv_prev[t]) begin
        n_checks++;
        if (q_resp.size() == 0) begin
          $display("FAIL resp_unexpected: actual result on thread %0d, required none", t);
        end else begin
          rexp_t e;
          logic [7:0] d;
          n_pass++;
          e = q_resp.pop_front();
          d = resp_data[8*t +: 8];
          chk("resp_thread", t, e.thr);
          chk("resp_data", d, e.data);
          chk("resp_div_zero", div_zero[t], e.dz);
        end
      end
    end
    rv_prev = resp_valid;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int t, input logic [1:0] op, input logic om,
                         input logic [7:0] rs, input logic [7:0] rt);
    req_arith_mux[2*t +: 2] = op;
    req_output_mux[t]       = om;
    req_rs[8*t +: 8]        = rs;
    req_rt[8*t +: 8]        = rt;
  endtask

  task automatic wait_grant(input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    n_checks++;
    if (got) n_pass++;
    else $display("FAIL grant_timeout: actual no req_ready, required one within %0d cycles", budget);
  endtask

  task automatic wait_rv(input int t, input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (resp_valid[t]) got = 1'b1;
    end
    n_checks++;
    if (got) n_pass++;
    else $display("FAIL resp_timeout: actual resp_valid[%0d]=0, required 1 within %0d cycles", t, budget);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && q_resp.size() != 0; k++) @(negedge clk);
    chk("drain_resp", q_resp.size(), 0);
  endtask

  task automatic ack_pulse(input logic [N-1:0] m);
    tick(); man_ack = m;
    tick(); man_ack = '0;
  endtask

  logic [7:0] tmp8;

  initial begin
    reset = 1'b1;
    req_valid = '1;
    req_arith_mux = '0; req_output_mux = '0; req_rs = '0; req_rt = '0;

    // Reset state, with requests already pending
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_resp_valid", resp_valid, 4'b0000);
    chk("rst_core_state", alu_core_state, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_alu_ops", {alu_arith_mux, alu_output_mux, alu_rs, alu_rt}, 0);
    tick(); req_valid = '0;
    tick(); reset = 1'b0;
    tick();

    // Single request: thread 1 ADD 200+100 -> 44
    push_g(4'b0010, 0); push_r(1, 8'd44, 1'b0);
    set_req(1, 2'b00, 1'b0, 8'd200, 8'd100);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("single_ready_c0", req_ready, 4'b0010);
    tick(); req_valid = '0;
    @(negedge clk);
    chk("single_exec_c1", alu_core_state, 3'b101);
    chk("single_busy_c1", busy, 1'b1);
    tick(); @(negedge clk);
    chk("single_capture_c2", {alu_core_state, resp_valid}, {3'b000, 4'b0000});
    tick(); @(negedge clk);
    chk("single_rv_c3", resp_valid, 4'b0010);
    tmp8 = resp_data[15:8];
    chk("single_data_c3", tmp8, 8'd44);
    ack_pulse(4'b0010);
    @(negedge clk);
    chk("single_ack_clear", resp_valid, 4'b0000);

    // Compare op on thread 3: 5 vs 5 -> EQ bit
    push_g(4'b1000, 0); push_r(3, 8'b0000_0010, 1'b0);
    tick();
    set_req(3, 2'b00, 1'b1, 8'd5, 8'd5);
    req_valid = 4'b1000;
    wait_grant(10);
    tick(); req_valid = '0;
    wait_rv(3, 10);
    ack_pulse(4'b1000);

    // Fairness: all valid, immediate acks, 8 grants 3 cycles apart
    for (int t = 0; t < N; t++) set_req(t, 2'b00, 1'b0, 8'(10*t + 1), 8'(t));
    for (int r = 0; r < 2; r++) begin
      push_g(4'b0001, (r == 0) ? 0 : 3); push_g(4'b0010, 3);
      push_g(4'b0100, 3); push_g(4'b1000, 3);
      push_r(0, 8'd1, 1'b0);  push_r(1, 8'd12, 1'b0);
      push_r(2, 8'd23, 1'b0); push_r(3, 8'd34, 1'b0);
    end
    auto_en = 1'b1;
    tick(); req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) wait_grant(10);
    tick(); req_valid = '0;
    wait_drain(20);
    repeat (3) tick();
    auto_en = 1'b0;
    tick();
    chk("fair_all_acked", resp_valid, 4'b0000);

    // Slot full blocks re-grant of thread 0
    set_req(0, 2'b00, 1'b0, 8'd1, 8'd2);
    set_req(2, 2'b01, 1'b0, 8'd3, 8'd5);
    push_g(4'b0001, 0); push_g(4'b0100, 3);
    push_r(0, 8'd3, 1'b0); push_r(2, 8'd254, 1'b0);
    req_valid = 4'b0101;
    wait_rv(2, 20);
    repeat (6) @(negedge clk);
    chk("full_idle_busy", busy, 1'b0);
    chk("full_slots", resp_valid, 4'b0101);
    ack_pulse(4'b0010);
    @(negedge clk);
    chk("ack_empty_ignored", resp_valid, 4'b0101);
    push_g(4'b0001, 0); push_r(0, 8'd3, 1'b0);
    tick(); man_ack = 4'b0001;
    tick(); man_ack = '0;
    wait_grant(10);
    tick(); req_valid = '0;
    tick(); man_ack = 4'b0100;
    tick(); man_ack = '0;
    @(negedge clk);
    chk("ack_during_capture", resp_valid, 4'b0001);
    ack_pulse(4'b0001);
    @(negedge clk);
    chk("full_all_clear", resp_valid, 4'b0000);

    // DIV by zero, MUL wrap, ordinary DIV
    set_req(1, 2'b11, 1'b0, 8'd9, 8'd0);
    set_req(2, 2'b10, 1'b0, 8'd20, 8'd13);
    set_req(3, 2'b11, 1'b0, 8'd100, 8'd7);
    push_g(4'b0010, 0); push_g(4'b0100, 3); push_g(4'b1000, 3);
    push_r(1, DZ_DATA, DZ_FLAG); push_r(2, 8'd4, 1'b0); push_r(3, 8'd14, 1'b0);
    tick(); req_valid = 4'b1110;
    wait_rv(3, 20);
    chk("dz_vector", div_zero, {2'b00, DZ_FLAG, 1'b0});
    tick(); req_valid = '0;
    ack_pulse(4'b1110);
    @(negedge clk);
    chk("dz_ack_clear", {resp_valid, div_zero}, 8'h00);

    // Reset during EXEC discards the op; thread 0 wins first afterwards
    set_req(2, 2'b00, 1'b0, 8'd7, 8'd8);
    push_g(4'b0100, 0);
    tick(); req_valid = 4'b0100;
    wait_grant(10);
    @(negedge clk);
    chk("rstmid_exec", alu_core_state, 3'b101);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_outputs", {alu_core_state, busy, req_ready, resp_valid, div_zero}, 0);
    chk("rstmid_alu_rs", alu_rs, 8'd0);
    push_g(4'b0001, 0); push_r(0, 8'd3, 1'b0);
    tick(); req_valid = 4'b1111; reset = 1'b0;
    wait_grant(10);
    tick(); req_valid = '0;
    wait_rv(0, 10);
    ack_pulse(4'b0001);
    repeat (3) tick();

    chk("sb_resp_drained", q_resp.size(), 0);
    chk("sb_gnt_drained", q_gnt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
